alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set command FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  command valid.
REQ-005 in_ready  output  1  command FIFO can accept a command.
REQ-006 in_a, in_b  input  4 each  operands.
REQ-007 in_s  input  3  opcode: 0 AND, 1 SUB, 2 ADD, 3 OR, 4 XOR, 5 DIV, 6 NOT a, 7 NOT b.
REQ-008 alu_a, alu_b  output  4 each  operands driven to the downstream combinational ALU.
REQ-009 alu_s  output  3  opcode driven to the ALU.
REQ-010 alu_y  input  8  ALU result; valid within the same cycle that alu_a/alu_b/alu_s are stable.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_y  output  8  captured result.
REQ-014 out_s  output  3  opcode echo of the captured result.
REQ-015 out_err  output  1  divide-by-zero flag for the captured result.
REQ-016 cmd_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-017 Push: command SHALL be written into the FIFO when in_valid && in_ready at a rising edge; in_ready SHALL equal (cmd_count < DEPTH), with no combinational path from out_ready.
REQ-018 FIFO SHALL be first-in first-out with wrapping read/write pointers; a simultaneous push and pop SHALL leave cmd_count unchanged.
REQ-019 FSM states SHALL be IDLE, EXEC, and HOLD.
REQ-020 IDLE: when cmd_count > 0, the FSM SHALL pop the head into operand registers and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-021 alu_a, alu_b, and alu_s SHALL be driven directly from the operand registers, changing only on a pop.
REQ-022 EXEC (exactly one cycle): at the closing edge, the block SHALL load out_y <= alu_y, out_s <= alu_s, and out_err <= (alu_s==5 && alu_b==0), and go to HOLD.
REQ-023 On divide-by-zero, out_y SHALL be forced to 8'h00 regardless of alu_y.
REQ-024 HOLD: out_valid SHALL be 1, and out_y/out_s/out_err SHALL stay stable until out_valid && out_ready.
REQ-025 On the HOLD handshake, if cmd_count > 0 the FSM SHALL pop and go to EXEC; otherwise it SHALL go to IDLE and clear out_valid.
REQ-026 out_valid SHALL be 1 only in HOLD.
REQ-027 Latency: a command pushed into an empty FIFO in IDLE at edge N SHALL be popped at N+1 and captured at N+2, with out_valid=1 after N+2.
REQ-028 Throughput: with out_ready held at 1, one result SHALL complete every 2 cycles.
REQ-029 Push SHALL be independent of FSM state; a command pushed in the same cycle the FIFO is empty SHALL NOT be popped in that cycle.
REQ-030 out_ready asserted outside HOLD SHALL be ignored.

Reset
REQ-031 When rst_n=0, asynchronously: FSM SHALL go to IDLE; pointers and cmd_count SHALL be 0; in_ready SHALL be 1; out_valid, out_y, out_s, out_err, alu_a, alu_b, and alu_s SHALL be 0.
REQ-032 A reset in EXEC or HOLD SHALL discard the in-flight result and all queued commands; no out_valid SHALL follow reset until a new command is pushed.
REQ-033 Reset deassertion SHALL be sampled synchronously; the first push SHALL be possible on the first edge after rst_n rises.

Verification
REQ-034 Single op: push a=9, b=3, s=2 with out_ready=1 -> out_valid 2 cycles after push, out_y=8'h0C, out_s=2, out_err=0, cmd_count back to 0.
REQ-035 Divide-by-zero: push a=7, b=0, s=5 -> out_y=8'h00, out_err=1; then push a=8, b=2, s=5 -> out_y=8'h04, out_err=0.
REQ-036 Fill/backpressure: out_ready=0, push 5 commands (AND 0xF,0x5; SUB 5,3; OR 1,2; XOR 0xF,0x1; NOT a 0x3) -> in_ready=0 once cmd_count=4 (one command in HOLD); the FIFO SHALL hold 4; release out_ready -> results 0x05, 0x02, 0x03, 0x0E, 0x0C in order.
REQ-037 Stall: hold out_ready=0 for 10 cycles in HOLD -> out_y/out_s/out_err unchanged and alu_* unchanged.
REQ-038 Reset mid-op: assert rst_n=0 in EXEC with 3 commands queued -> all outputs 0 immediately; after release, no out_valid without a new push.
REQ-039 Throughput: stream 8 random commands with out_ready=1 -> one out_valid pulse every 2 cycles, each result matching the opcode table, with NOT results zero-extended (e.g. s=7, b=0x6 -> 8'h09).

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands in a small FIFO and sequences them one at a time through an external combinational ALU.
// Pop 1 cycle after push into an empty queue, result held 2 cycles after push; in_ready depends only on occupancy, and results stall in HOLD until out_ready.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [2:0]               in_s,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_s,
  input  logic [7:0]               alu_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_y,
  output logic [2:0]               out_s,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wptr, rptr;
  logic          push, pop, not_empty, div_zero;

  assign in_ready  = (cmd_count < DEPTH_C);
  assign not_empty = (cmd_count != '0);
  assign push      = in_valid && in_ready;
  assign head      = mem[rptr];
  assign out_valid = (state_q == HOLD);
  assign div_zero  = (alu_s == 3'd5) && (alu_b == 4'd0);

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_a, in_b, in_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pop decisions use registered occupancy, so a same-cycle push is never popped.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (not_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
    end else if (pop) begin
      alu_a <= head.a;
      alu_b <= head.b;
      alu_s <= head.s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y   <= '0;
      out_s   <= '0;
      out_err <= 1'b0;
    end else if (state_q == EXEC) begin
      out_y   <= div_zero ? 8'h00 : alu_y;
      out_s   <= alu_s;
      out_err <= div_zero;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* side.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic [2:0] in_s = '0;
  logic       in_ready, out_valid, out_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_s, out_s;
  logic [7:0] alu_y, out_y;
  logic [2:0] cmd_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] expq[$];

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_s(out_s), .out_err(out_err),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Downstream ALU; divide by zero returns junk so the forced zero is visible.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    logic [7:0] ea, eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (s)
      3'd0:    return ea & eb;
      3'd1:    return ea - eb;
      3'd2:    return ea + eb;
      3'd3:    return ea | eb;
      3'd4:    return ea ^ eb;
      3'd5:    return (b == 4'd0) ? 8'hFF : ea / eb;
      3'd6:    return {4'h0, ~a};
      default: return {4'h0, ~b};
    endcase
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_s);

  function automatic logic [11:0] exp_res(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    logic err;
    err = (s == 3'd5) && (b == 4'd0);
    return {err, s, err ? 8'h00 : alu_f(a, b, s)};
  endfunction

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic [7:0] y;
    logic       err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    in_a = a; in_b = b; in_s = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_cmd_count"}, cmd_count, 0);
    chk({tag, "_out_res"}, {out_err, out_s, out_y}, 0);
    chk({tag, "_alu_ops"}, {alu_a, alu_b, alu_s}, 0);
  endtask

  // Pops expected {err,s,y} records as results appear; optional 2-cycle spacing check.
  task automatic collect(input int n, input bit gap_chk);
    int got = 0;
    int last = -1;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (out_valid) begin
        chk("result", {out_err, out_s, out_y}, expq.pop_front());
        if (gap_chk && last >= 0) chk("result_gap", c - last, 2);
        last = c;
        got++;
      end
      tick();
    end
    chk("result_count", got, n);
  endtask

  initial begin
    vt[0]  = '{4'h9, 4'h3, 3'd2, 8'h0C, 1'b0};
    vt[1]  = '{4'h7, 4'h0, 3'd5, 8'h00, 1'b1};
    vt[2]  = '{4'h8, 4'h2, 3'd5, 8'h04, 1'b0};
    vt[3]  = '{4'hC, 4'hA, 3'd0, 8'h08, 1'b0};
    vt[4]  = '{4'h2, 4'h5, 3'd1, 8'hFD, 1'b0};
    vt[5]  = '{4'h9, 4'h6, 3'd3, 8'h0F, 1'b0};
    vt[6]  = '{4'hA, 4'hF, 3'd4, 8'h05, 1'b0};
    vt[7]  = '{4'h5, 4'h0, 3'd6, 8'h0A, 1'b0};
    vt[8]  = '{4'h0, 4'h6, 3'd7, 8'h09, 1'b0};
    vt[9]  = '{4'hF, 4'h4, 3'd5, 8'h03, 1'b0};
    vt[10] = '{4'hF, 4'hF, 3'd2, 8'h1E, 1'b0};

    #2 rst_n = 1'b0;
    #1 chk_reset("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Single commands: push at N, pop at N+1, result held after N+2.
    out_ready = 1'b1;
    foreach (vt[i]) begin
      push_one(vt[i].a, vt[i].b, vt[i].s);
      chk("push_count", cmd_count, 1);
      chk("push_valid", out_valid, 0);
      tick();
      chk("pop_valid", out_valid, 0);
      chk("pop_count", cmd_count, 0);
      chk("pop_alu_ops", {alu_a, alu_b, alu_s}, {vt[i].a, vt[i].b, vt[i].s});
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_y", out_y, vt[i].y);
      chk("hold_s", out_s, vt[i].s);
      chk("hold_err", out_err, vt[i].err);
      tick();
      chk("done_valid", out_valid, 0);
      chk("done_count", cmd_count, 0);
    end

    // Stall in HOLD for 10 cycles with a second command waiting.
    out_ready = 1'b0;
    push_one(4'h6, 4'h3, 3'd1);
    tick();
    tick();
    push_one(4'h4, 4'h1, 3'd2);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_res", {out_err, out_s, out_y}, {1'b0, 3'd1, 8'h03});
      chk("stall_alu_ops", {alu_a, alu_b, alu_s}, {4'h6, 4'h3, 3'd1});
      chk("stall_count", cmd_count, 1);
      tick();
    end
    expq.push_back({1'b0, 3'd1, 8'h03});
    expq.push_back({1'b0, 3'd2, 8'h05});
    out_ready = 1'b1;
    collect(2, 1'b1);

    // Fill: one command in HOLD plus four queued, then a rejected push.
    out_ready = 1'b0;
    tick();
    chk("fill_start_count", cmd_count, 0);
    push_one(4'hF, 4'h5, 3'd0);
    push_one(4'h5, 4'h3, 3'd1);
    push_one(4'h1, 4'h2, 3'd3);
    push_one(4'hF, 4'h1, 3'd4);
    chk("fill_ready_before_last", in_ready, 1);
    push_one(4'h3, 4'h0, 3'd6);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", cmd_count, 4);
    chk("fill_valid", out_valid, 1);
    push_one(4'h1, 4'h1, 3'd2);
    chk("full_push_ignored", cmd_count, 4);
    chk("full_head_res", {out_err, out_s, out_y}, {1'b0, 3'd0, 8'h05});
    expq.push_back({1'b0, 3'd0, 8'h05});
    expq.push_back({1'b0, 3'd1, 8'h02});
    expq.push_back({1'b0, 3'd3, 8'h03});
    expq.push_back({1'b0, 3'd4, 8'h0E});
    expq.push_back({1'b0, 3'd6, 8'h0C});
    out_ready = 1'b1;
    collect(5, 1'b1);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_count", cmd_count, 0);

    // Reset while in EXEC with three commands queued.
    out_ready = 1'b0;
    push_one(4'h9, 4'h3, 3'd2);
    push_one(4'h1, 4'h2, 3'd3);
    push_one(4'h2, 4'h2, 3'd2);
    push_one(4'h7, 4'h1, 3'd4);
    out_ready = 1'b1;
    push_one(4'h3, 4'h3, 3'd2);
    out_ready = 1'b0;
    chk("midop_count", cmd_count, 3);
    chk("midop_exec_valid", out_valid, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("midop_reset");
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("post_reset_valid", out_valid, 0);
      chk("post_reset_count", cmd_count, 0);
      tick();
    end
    expq.push_back(exp_res(4'hB, 4'h2, 3'd1));
    push_one(4'hB, 4'h2, 3'd1);
    collect(1, 1'b0);

    // Streaming with out_ready held high.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_a = 4'($urandom_range(0, 15));
          in_b = 4'($urandom_range(0, 15));
          in_s = 3'($urandom_range(0, 7));
          if (i == 0) begin
            in_s = 3'd7;
            in_b = 4'h6;
          end
          in_valid = 1'b1;
          for (int w = 0; w < 50 && !in_ready; w++) tick();
          chk("stream_in_ready", in_ready, 1);
          expq.push_back(exp_res(in_a, in_b, in_s));
          tick();
          in_valid = 1'b0;
        end
      end
      collect(8, 1'b1);
    join
    tick();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_end_count", cmd_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
